hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage core; successor to the load-use-only detector.
//  Adds: 1- or 2-cycle load-use distance, Rs-usage qualification, multi-cycle mul/div EX stall (FSM),
//  data-memory wait freeze, taken-branch flush, saturating stall/flush performance counters.
//  Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB write-enable and bubble controls.
// PARAMETERS
//  REG_ADDR_WIDTH   5  register index width; index 0 is hardwired zero and never causes a hazard
//  LOAD_LATENCY     1  load data cycles past MEM (1 or 2); 2 also stalls on an EX/MEM load producer
//  MULDIV_LATENCY   4  EX occupancy of a mul/div op in cycles (>=1); 1 means no stall
//  CNT_WIDTH       16  width of the performance counters
// PORTS
//  clk            in   1    clock, rising edge
//  reset          in   1    synchronous, active-high
//  IF_ID_Rs1      in   RAW  source 1 of decoding instr (RAW = REG_ADDR_WIDTH)
//  IF_ID_Rs2      in   RAW  source 2 of decoding instr
//  IF_ID_UsesRs1  in   1    decoding instr reads Rs1
//  IF_ID_UsesRs2  in   1    decoding instr reads Rs2
//  ID_EX_MemRead  in   1    EX-stage instr is a load
//  ID_EX_Rd       in   RAW  EX-stage destination
//  ID_EX_MulDiv   in   1    EX-stage instr is mul/div
//  EX_MEM_MemRead in   1    MEM-stage instr is a load
//  EX_MEM_Rd      in   RAW  MEM-stage destination
//  MEM_Req        in   1    MEM stage has an active data-memory access
//  dmem_ready     in   1    data memory completes the access this cycle
//  branch_taken   in   1    EX resolved a taken branch/jump
//  PCWrite        out  1    PC update enable
//  IF_ID_Write    out  1    IF/ID register enable
//  IF_ID_Flush    out  1    IF/ID cleared to NOP
//  ID_EX_Write    out  1    ID/EX register enable
//  ID_EX_Bubble   out  1    ID/EX loads NOP
//  EX_MEM_Write   out  1    EX/MEM enable
//  EX_MEM_Bubble  out  1    EX/MEM loads NOP
//  MEM_WB_Write   out  1    MEM/WB enable
//  MEM_WB_Bubble  out  1    MEM/WB loads NOP
//  stall          out  1    any stall/freeze this cycle
//  stall_cycles   out  CNT_WIDTH  saturating count of stall cycles
//  flush_count    out  CNT_WIDTH  saturating count of branch flushes
// BEHAVIOUR
//  - Reset (sync): FSM->RUN, md_cnt=0, counters=0. While reset=1 all *_Write=1, all Flush/Bubble=0, stall=0.
//  - Priority per cycle: mem_freeze > md_busy > branch flush > load-use.
//  - mem_freeze = MEM_Req & ~dmem_ready: PCWrite, IF_ID/ID_EX/EX_MEM_Write=0; MEM_WB_Bubble=1.
//    FSM state and md_cnt hold; flush and load-use suppressed (branch_taken held since EX is frozen).
//  - FSM RUN -> MD_BUSY when ID_EX_MulDiv & MULDIV_LATENCY>1 & ~mem_freeze; md_cnt<=MULDIV_LATENCY-2.
//    Entry cycle and each MD_BUSY cycle: PCWrite, IF_ID_Write, ID_EX_Write=0; EX_MEM_Bubble=1.
//    MD_BUSY: md_cnt==0 -> RUN (op enters EX/MEM next edge); else md_cnt--. Total stall = MULDIV_LATENCY-1 cycles.
//  - Flush (RUN, no freeze): branch_taken -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1; overrides load-use.
//  - Load-use (RUN): hit(Rd) = Rd!=0 & ((UsesRs1 & Rd==Rs1) | (UsesRs2 & Rd==Rs2)).
//    Stall if ID_EX_MemRead & hit(ID_EX_Rd), or LOAD_LATENCY==2 & EX_MEM_MemRead & hit(EX_MEM_Rd):
//    PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Combinational; repeats while condition holds.
//  - stall = ~PCWrite. stall_cycles += stall; flush_count += IF_ID_Flush; both saturate at all-ones.
//  - Reset mid MD_BUSY or freeze: abandoned; RUN next cycle, no residual stall.
//  - All control outputs combinational from inputs + registered state; zero latency.
// STRUCTURE
//  - hazard_defs.vh: FSM state encodings (ST_RUN, ST_MD_BUSY), default REG_ADDR_WIDTH, NOP control constants.
//  - One sub-module: hazard_sat_counter (CNT_WIDTH, clk, reset, inc, count), instanced twice.
// TESTING
//  - ID_EX load x5, IF_ID add x6,x5,x7 (UsesRs1=1) -> 1 cycle PCWrite=0, ID_EX_Bubble=1, stall_cycles=1.
//  - Load into x0, or Rs2 match with UsesRs2=0 -> no stall, all *_Write=1.
//  - LOAD_LATENCY=2, EX_MEM load x5, consumer of x5 in IF/ID -> stall; LOAD_LATENCY=1 same -> no stall.
//  - MULDIV_LATENCY=4, ID_EX_MulDiv=1 -> exactly 3 cycles EX_MEM_Bubble=1 and PCWrite=0, then RUN.
//  - MD_BUSY with md_cnt=1 plus MEM_Req & ~dmem_ready for 2 cycles -> md_cnt held, total MD stall 5 cycles.
//  - branch_taken with a concurrent load-use hit -> IF_ID_Flush=1, PCWrite=1, flush_count=1; reset mid-MD -> RUN.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The control word bundles every pipeline-register enable and bubble/flush line.
package hazard_ctrl_unit_pkg;

  localparam int unsigned DefRegAddrWidth = 5;

  typedef enum logic [0:0] {
    StRun,
    StMdBusy
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic ex_mem_bubble;
    logic mem_wb_write;
    logic mem_wb_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CtrlRun     = hz_ctrl_t'(9'b110101010);
  localparam hz_ctrl_t CtrlLoadUse = hz_ctrl_t'(9'b000111010);
  localparam hz_ctrl_t CtrlFlush   = hz_ctrl_t'(9'b111111010);
  localparam hz_ctrl_t CtrlMdStall = hz_ctrl_t'(9'b000001110);
  localparam hz_ctrl_t CtrlFreeze  = hz_ctrl_t'(9'b000000101);

  function automatic logic reg_hit(input logic [31:0] rd, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic uses_rs1,
                                   input logic uses_rs2);
    return (rd != '0) && ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module hazard_sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: memory-wait freeze, mul/div EX stall, branch flush and load-use
// interlock, with saturating stall/flush counters.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = DefRegAddrWidth,
  parameter int unsigned LOAD_LATENCY   = 1,
  parameter int unsigned MULDIV_LATENCY = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rs2,
  input  logic                      IF_ID_UsesRs1,
  input  logic                      IF_ID_UsesRs2,
  input  logic                      ID_EX_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_Rd,
  input  logic                      ID_EX_MulDiv,
  input  logic                      EX_MEM_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_Rd,
  input  logic                      MEM_Req,
  input  logic                      dmem_ready,
  input  logic                      branch_taken,
  output logic                      PCWrite,
  output logic                      IF_ID_Write,
  output logic                      IF_ID_Flush,
  output logic                      ID_EX_Write,
  output logic                      ID_EX_Bubble,
  output logic                      EX_MEM_Write,
  output logic                      EX_MEM_Bubble,
  output logic                      MEM_WB_Write,
  output logic                      MEM_WB_Bubble,
  output logic                      stall,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam int unsigned MdCntW = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY - 1) : 1;
  localparam logic [MdCntW-1:0] MdInit =
      MdCntW'((MULDIV_LATENCY > 1) ? MULDIV_LATENCY - 2 : 0);

  hz_state_e         state_q, state_d;
  logic [MdCntW-1:0] md_cnt_q, md_cnt_d;
  hz_ctrl_t          ctrl;
  logic              mem_freeze, md_stall, hit_ex, hit_mem, load_use;

  assign mem_freeze = MEM_Req && !dmem_ready;
  assign hit_ex  = reg_hit(32'(ID_EX_Rd), 32'(IF_ID_Rs1), 32'(IF_ID_Rs2),
                           IF_ID_UsesRs1, IF_ID_UsesRs2);
  assign hit_mem = reg_hit(32'(EX_MEM_Rd), 32'(IF_ID_Rs1), 32'(IF_ID_Rs2),
                           IF_ID_UsesRs1, IF_ID_UsesRs2);
  assign load_use = (ID_EX_MemRead && hit_ex) ||
                    ((LOAD_LATENCY == 2) && EX_MEM_MemRead && hit_mem);

  always_comb begin
    ctrl     = CtrlRun;
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_stall = 1'b0;
    if (reset) begin
      state_d  = StRun;
      md_cnt_d = '0;
    end else if (mem_freeze) begin
      ctrl = CtrlFreeze;
    end else begin
      // The md_cnt==0 cycle releases the op into EX/MEM, so it is not itself a stall.
      if (state_q == StMdBusy) begin
        if (md_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
          md_stall = 1'b1;
        end
      end else if (ID_EX_MulDiv && (MULDIV_LATENCY > 1)) begin
        state_d  = StMdBusy;
        md_cnt_d = MdInit;
        md_stall = 1'b1;
      end
      if (md_stall) begin
        ctrl = CtrlMdStall;
      end else if (branch_taken) begin
        ctrl = CtrlFlush;
      end else if (load_use) begin
        ctrl = CtrlLoadUse;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign PCWrite       = ctrl.pc_write;
  assign IF_ID_Write   = ctrl.if_id_write;
  assign IF_ID_Flush   = ctrl.if_id_flush;
  assign ID_EX_Write   = ctrl.id_ex_write;
  assign ID_EX_Bubble  = ctrl.id_ex_bubble;
  assign EX_MEM_Write  = ctrl.ex_mem_write;
  assign EX_MEM_Bubble = ctrl.ex_mem_bubble;
  assign MEM_WB_Write  = ctrl.mem_wb_write;
  assign MEM_WB_Bubble = ctrl.mem_wb_bubble;
  assign stall         = !ctrl.pc_write;

  hazard_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall),
    .count(stall_cycles)
  );

  hazard_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (IF_ID_Flush),
    .count(flush_count)
  );

endmodule
